// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor. The carry chain is cut into STAGES slices with a
// registered carry between them; a global stall freezes every stage including the outputs.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

  localparam int SLICE = WIDTH / STAGES;

  // Stage k holds operands, the partial result (bits below k*SLICE) and the carry into slice k.
  logic [STAGES-1:0]            r_v;
  logic [STAGES-1:0][WIDTH-1:0] r_a;
  logic [STAGES-1:0][WIDTH-1:0] r_b;
  logic [STAGES-1:0][WIDTH-1:0] r_s;
  logic [STAGES-1:0]            r_c;

  logic [STAGES-1:0][SLICE:0]   w_slice;
  logic [STAGES-1:0][WIDTH-1:0] w_snext;

  logic             r_out_v;
  logic [WIDTH-1:0] r_sum;
  logic             r_co;
  logic             r_ovf;
  logic             r_zero;

  logic             w_adv;
  logic [WIDTH-1:0] w_final;
  logic             w_final_co;
  logic             w_ovf;

  assign w_adv    = !r_out_v || out_ready;
  assign in_ready = w_adv;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_slice[k] = {1'b0, r_a[k][k*SLICE +: SLICE]}
                 + {1'b0, r_b[k][k*SLICE +: SLICE]}
                 + {{SLICE{1'b0}}, r_c[k]};
      w_snext[k] = r_s[k];
      w_snext[k][k*SLICE +: SLICE] = w_slice[k][SLICE-1:0];
    end
  end

  assign w_final    = w_snext[STAGES-1];
  assign w_final_co = w_slice[STAGES-1][SLICE];
  // r_b already holds ~b in subtract mode, so this is the usual same-sign/different-result test.
  assign w_ovf      = (r_a[STAGES-1][WIDTH-1] == r_b[STAGES-1][WIDTH-1]) &&
                      (w_final[WIDTH-1] != r_a[STAGES-1][WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v     <= '0;
      r_out_v <= 1'b0;
      r_sum   <= '0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_adv) begin
      r_v[0] <= in_valid;
      if (in_valid) begin
        r_a[0] <= a;
        r_b[0] <= sub ? ~b : b;
        r_c[0] <= sub ? ~ci : ci;
        r_s[0] <= '0;
      end
      for (int k = 1; k < STAGES; k++) begin
        r_v[k] <= r_v[k-1];
        r_a[k] <= r_a[k-1];
        r_b[k] <= r_b[k-1];
        r_s[k] <= w_snext[k-1];
        r_c[k] <= w_slice[k-1][SLICE];
      end
      r_out_v <= r_v[STAGES-1];
      // Bubbles leave the result/flags untouched so they keep their last meaningful value.
      if (r_v[STAGES-1]) begin
        r_sum  <= w_final;
        r_co   <= w_final_co;
        r_ovf  <= w_ovf;
        r_zero <= (w_final == '0);
      end
    end
  end

  assign out_valid = r_out_v;
  assign sum       = r_sum;
  assign co        = r_co;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: directed table, streaming/stall, reset, and
// randomized traffic on three configurations (32/4, 32/1, 8/8) against an arithmetic model.
module tb_pipelined_addsub;

  typedef struct packed {
    logic [31:0] sum;
    logic        co;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ovf;
    logic        zero;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv   [3];
  logic        ordy [3];
  logic        cin  [3];
  logic        sb   [3];
  logic [31:0] ia   [3];
  logic [31:0] ib   [3];
  wire         in_rdy [3];
  wire         ov     [3];
  wire         co_o   [3];
  wire         ovf_o  [3];
  wire         zr     [3];
  wire  [31:0] sm     [3];
  wire  [7:0]  sum8;

  int n_cmp = 0;
  int n_bad = 0;
  int wd [3] = '{32, 32, 8};

  assign sm[2] = {24'h0, sum8};

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(in_rdy[0]), .a(ia[0]), .b(ib[0]),
    .ci(cin[0]), .sub(sb[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sm[0]),
    .co(co_o[0]), .ovf(ovf_o[0]), .zero(zr[0]));

  pipelined_addsub #(.WIDTH(32), .STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(in_rdy[1]), .a(ia[1]), .b(ib[1]),
    .ci(cin[1]), .sub(sb[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sm[1]),
    .co(co_o[1]), .ovf(ovf_o[1]), .zero(zr[1]));

  pipelined_addsub #(.WIDTH(8), .STAGES(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(in_rdy[2]), .a(ia[2][7:0]), .b(ib[2][7:0]),
    .ci(cin[2]), .sub(sb[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sum8),
    .co(co_o[2]), .ovf(ovf_o[2]), .zero(zr[2]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: true integer arithmetic, co = carry-out (add) or NOT borrow (sub),
  // ovf = signed result outside the w-bit two's-complement range.
  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic sub);
    longint full, half, ua, ub, sa, sb_, u, s;
    res_t r;
    full = longint'(1) << w;
    half = full >> 1;
    ua = longint'(a) & (full - 1);
    ub = longint'(b) & (full - 1);
    sa = (ua >= half) ? ua - full : ua;
    sb_ = (ub >= half) ? ub - full : ub;
    if (sub) begin
      u = ua - ub - longint'(ci);
      s = sa - sb_ - longint'(ci);
      r.co = (u >= 0);
    end else begin
      u = ua + ub + longint'(ci);
      s = sa + sb_ + longint'(ci);
      r.co = (u >= full);
    end
    r.sum  = 32'(u & (full - 1));
    r.ovf  = (s >= half) || (s < -half);
    r.zero = (r.sum == 32'h0);
    return r;
  endfunction

  // Streams a=i,b=i for i=0..7 into the 32/4 instance; out_ready low for iterations stall_lo..stall_hi.
  task automatic stream(input int stall_lo, input int stall_hi, input string tag);
    int idx = 0;
    int got = 0;
    int first = -1;
    bit stalled;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      stalled  = (cyc >= stall_lo) && (cyc <= stall_hi);
      iv[0]    = (idx < 8);
      ia[0]    = idx;
      ib[0]    = idx;
      cin[0]   = 1'b0;
      sb[0]    = 1'b0;
      ordy[0]  = !stalled;
      #1;
      if (ov[0] && first < 0) first = cyc - 1;
      if (stalled) begin
        chk({tag, "_stall_in_ready"}, in_rdy[0], 0);
        chk({tag, "_stall_sum"}, sm[0], 2);
        chk({tag, "_stall_valid"}, ov[0], 1);
      end
      if (ov[0] && ordy[0]) begin
        chk($sformatf("%s_sum%0d", tag, got), sm[0], 2 * got);
        if (stall_lo < 0) chk($sformatf("%s_edge%0d", tag, got), cyc - 1, 4 + got);
        got++;
      end
      if (iv[0] && in_rdy[0]) idx++;
    end
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    chk({tag, "_count"}, got, 8);
    chk({tag, "_accepted"}, idx, 8);
    chk({tag, "_first_edge"}, first, 4);
  endtask

  vec_t vt [9];
  res_t q  [3][$];

  initial begin
    int lat;
    int acc_n [3];
    int del_n [3];
    bit pv_stall [3];
    logic [31:0] pv_sum [3];
    logic pv_co [3], pv_ovf [3], pv_zero [3];
    res_t e;
    logic [31:0] mask;

    vt[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vt[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vt[2] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vt[3] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vt[4] = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000006, 1'b1, 1'b0, 1'b0};
    vt[5] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vt[6] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vt[7] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
    vt[8] = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b1; cin[d] = 1'b0; sb[d] = 1'b0; ia[d] = '0; ib[d] = '0;
      acc_n[d] = 0; del_n[d] = 0; pv_stall[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", ov[0], 0);
    chk("rst_sum", sm[0], 0);
    chk("rst_co", co_o[0], 0);
    chk("rst_ovf", ovf_o[0], 0);
    chk("rst_zero", zr[0], 0);
    chk("rst_in_ready", in_rdy[0], 1);

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      iv[0] = 1'b1; ia[0] = vt[i].a; ib[0] = vt[i].b; cin[0] = vt[i].ci; sb[0] = vt[i].sub;
      #1;
      chk($sformatf("dir%0d_in_ready", i), in_rdy[0], 1);
      @(negedge clk);
      iv[0] = 1'b0;
      ia[0] = $urandom; ib[0] = $urandom;
      lat = 0;
      while (!ov[0] && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      chk($sformatf("dir%0d_latency", i), lat, 4);
      chk($sformatf("dir%0d_sum", i), sm[0], vt[i].s);
      chk($sformatf("dir%0d_co", i), co_o[0], vt[i].co);
      chk($sformatf("dir%0d_ovf", i), ovf_o[0], vt[i].ovf);
      chk($sformatf("dir%0d_zero", i), zr[0], vt[i].zero);
    end
    repeat (3) @(negedge clk);

    stream(-1, -1, "stream");
    repeat (3) @(negedge clk);
    stream(6, 8, "stall");
    repeat (3) @(negedge clk);

    // Reset mid-operation: two ops accepted, third presented while rst is high.
    iv[0] = 1'b1; ia[0] = 1; ib[0] = 1; cin[0] = 1'b0; sb[0] = 1'b0;
    @(negedge clk); ia[0] = 2; ib[0] = 2;
    @(negedge clk); ia[0] = 3; ib[0] = 3; rst = 1'b1;
    @(negedge clk); rst = 1'b0; iv[0] = 1'b0;
    #1;
    chk("midrst_in_ready", in_rdy[0], 1);
    chk("midrst_sum", sm[0], 0);
    chk("midrst_co", co_o[0], 0);
    chk("midrst_ovf", ovf_o[0], 0);
    chk("midrst_zero", zr[0], 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("midrst_valid%0d", c), ov[0], 0);
      chk($sformatf("midrst_sum%0d", c), sm[0], 0);
    end

    // Randomized traffic on all three instances against the arithmetic model.
    for (int cyc = 0; cyc < 15100; cyc++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        mask   = (wd[d] == 32) ? 32'hFFFFFFFF : ((32'h1 << wd[d]) - 32'h1);
        iv[d]  = (cyc < 15000) && ($urandom_range(0, 99) < 80);
        ia[d]  = $urandom & mask;
        ib[d]  = $urandom & mask;
        if ($urandom_range(0, 7) == 0) ib[d] = ia[d];
        cin[d] = 1'($urandom_range(0, 1));
        sb[d]  = 1'($urandom_range(0, 1));
        ordy[d] = (cyc >= 15000) || ($urandom_range(0, 99) < 80);
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("rnd%0d_in_ready", d), in_rdy[d], !ov[d] || ordy[d]);
        if (pv_stall[d]) begin
          chk($sformatf("rnd%0d_hold_valid", d), ov[d], 1);
          chk($sformatf("rnd%0d_hold_sum", d), sm[d], pv_sum[d]);
          chk($sformatf("rnd%0d_hold_flags", d), {co_o[d], ovf_o[d], zr[d]},
              {pv_co[d], pv_ovf[d], pv_zero[d]});
        end
        if (ov[d] && ordy[d]) begin
          if (q[d].size() == 0) begin
            chk($sformatf("rnd%0d_unexpected", d), 1, 0);
          end else begin
            e = q[d].pop_front();
            chk($sformatf("rnd%0d_sum", d), sm[d], e.sum);
            chk($sformatf("rnd%0d_co", d), co_o[d], e.co);
            chk($sformatf("rnd%0d_ovf", d), ovf_o[d], e.ovf);
            chk($sformatf("rnd%0d_zero", d), zr[d], e.zero);
          end
          del_n[d]++;
        end
        if (iv[d] && in_rdy[d]) begin
          q[d].push_back(model(wd[d], ia[d], ib[d], cin[d], sb[d]));
          acc_n[d]++;
        end
        pv_stall[d] = ov[d] && !ordy[d];
        pv_sum[d]   = sm[d];
        pv_co[d]    = co_o[d];
        pv_ovf[d]   = ovf_o[d];
        pv_zero[d]  = zr[d];
      end
    end
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rnd%0d_leftover", d), q[d].size(), 0);
      chk($sformatf("rnd%0d_delivered", d), del_n[d], acc_n[d]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
